// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: PC-select codes, NOP encoding and fetch FSM states shared with the decoder
package fetch_pc_unit_pkg;
  localparam logic [2:0] PC_FROM_PC_PLUS_4 = 3'd0;
  localparam logic [2:0] PC_PLUS_JAL_IMM   = 3'd1;
  localparam logic [2:0] NEXT_PC_FROM_RF   = 3'd2;
  localparam logic [2:0] PC_PLUS_BRCH_IMM  = 3'd3;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_EXEC = 2'd2, S_HALT = 2'd3} state_e;
endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// next_pc_calc: immediate extraction and next-PC target selection, purely combinational
module next_pc_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:7] inst,
  input  logic [31:0] rs1_data,
  input  logic [2:0]  next_pc_sel,
  input  logic        alu_zero,
  output logic [31:0] pc_plus_4,
  output logic [31:0] next_target
);
  logic [31:0] j_imm, b_imm, i_imm, rf_sum;
  always_comb begin
    pc_plus_4 = pc + 32'd4;
    j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    i_imm = {{20{inst[31]}}, inst[31:20]};
    rf_sum = rs1_data + i_imm;
    next_target = next_pc_sel == PC_PLUS_JAL_IMM ? pc + j_imm :
                  next_pc_sel == NEXT_PC_FROM_RF ? {rf_sum[31:1], 1'b0} :
                  (next_pc_sel == PC_PLUS_BRCH_IMM && alu_zero) ? pc + b_imm : pc_plus_4;
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, fetches over the imem handshake and commits the decoder-selected next PC
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_encoding,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  input  logic [2:0]  next_pc_sel,
  input  logic [31:0] rs1_data,
  input  logic        alu_zero,
  input  logic        stall,
  output logic        misaligned_err
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, next_target;
  logic err_q, err_d;
  next_pc_calc u_calc (
    .pc(pc_q),
    .inst(inst_q[31:7]),
    .rs1_data(rs1_data),
    .next_pc_sel(next_pc_sel),
    .alu_zero(alu_zero),
    .pc_plus_4(pc_plus_4),
    .next_target(next_target)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    err_d = err_q;
    if (state_q == S_FETCH && imem_ready) state_d = S_WAIT;
    if (state_q == S_WAIT && imem_rvalid) begin
      inst_d = imem_rdata;
      state_d = S_EXEC;
    end
    // a misaligned target is never committed; the PC keeps the faulting instruction's address
    if (state_q == S_EXEC && !stall) begin
      state_d = next_target[1:0] != 2'b00 ? S_HALT : S_FETCH;
      pc_d = next_target[1:0] != 2'b00 ? pc_q : next_target;
      err_d = err_q | (next_target[1:0] != 2'b00);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      inst_q <= NOP;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      err_q <= err_d;
    end
  end
  assign imem_req = state_q == S_FETCH && !rst;
  assign imem_addr = pc_q;
  assign inst_valid = state_q == S_EXEC;
  assign inst_encoding = inst_q;
  assign pc = pc_q;
  assign misaligned_err = err_q;
endmodule
